// File: rtl/ffn_pkg.sv
// Shared types and arithmetic helpers for the sequential feedforward engine.
package ffn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_L1,
        ST_L2,
        ST_DONE
    } state_t;

    localparam int SAT_W = 64;

    typedef struct packed {
        logic signed [SAT_W-1:0] value;
        logic                    ovf;
    } sat_t;

    function automatic int acc_width(input int width, input int idim, input int hdim);
        int n = (idim > hdim) ? idim : hdim;
        return 2 * width + $clog2(n) + 1;
    endfunction

    // Clamp to the signed range of 'width' bits; ovf flags any clamp.
    function automatic sat_t saturate(input logic signed [SAT_W-1:0] v, input int width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_t r;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (width - 1));
        r.value = v;
        r.ovf   = 1'b0;
        if (v > hi) begin
            r.value = hi;
            r.ovf   = 1'b1;
        end else if (v < lo) begin
            r.value = lo;
            r.ovf   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ffn_seq_engine_mac.sv
// Time-multiplexed signed MAC with rescale, bias, optional ReLU and saturation.
module ffn_mac
    import ffn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    last,
    input  logic                    clr,
    input  logic                    relu,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    input  logic signed [WIDTH-1:0] bias,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   sum;
    logic signed [ACC_W-1:0]   scaled;
    logic signed [ACC_W-1:0]   biased;
    logic signed [SAT_W-1:0]   pre;
    sat_t                      sat;

    // The result is formed from acc+product so write-back needs no extra cycle.
    always_comb begin
        prod   = a * b;
        sum    = acc + ACC_W'(prod);
        scaled = sum >>> FRAC;
        biased = scaled + ACC_W'(bias);
        pre    = SAT_W'(biased);
        if (relu && biased[ACC_W-1]) begin
            pre = '0;
        end
        sat    = saturate(pre, WIDTH);
        result = WIDTH'(sat.value);
        ovf    = sat.ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/ffn_seq_engine.sv
// Sequential two-layer FFN: y = W2*ReLU(W1*x + b1) + b2 on a single shared MAC.
module ffn_seq_engine
    import ffn_pkg::*;
#(
    parameter int IDIM       = 4,
    parameter int HIDDEN_DIM = 8,
    parameter int WIDTH      = 8,
    parameter int FRAC       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               clear,
    input  logic [IDIM*WIDTH-1:0]              input_data,
    input  logic [HIDDEN_DIM*IDIM*WIDTH-1:0]   weights1,
    input  logic [HIDDEN_DIM*WIDTH-1:0]        bias1,
    input  logic [IDIM*HIDDEN_DIM*WIDTH-1:0]   weights2,
    input  logic [IDIM*WIDTH-1:0]              bias2,
    output logic [IDIM*WIDTH-1:0]              output_data,
    output logic                               busy,
    output logic                               done,
    output logic                               sat_flag
);

    localparam int ACC_W = acc_width(WIDTH, IDIM, HIDDEN_DIM);
    localparam int NW    = IDIM * HIDDEN_DIM;
    localparam int IW    = (IDIM > 1) ? $clog2(IDIM) : 1;
    localparam int HW    = (HIDDEN_DIM > 1) ? $clog2(HIDDEN_DIM) : 1;
    localparam int WW    = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(IDIM - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HIDDEN_DIM - 1);

    logic signed [WIDTH-1:0] x_r    [IDIM];
    logic signed [WIDTH-1:0] w1_r   [NW];
    logic signed [WIDTH-1:0] b1_r   [HIDDEN_DIM];
    logic signed [WIDTH-1:0] w2_r   [NW];
    logic signed [WIDTH-1:0] b2_r   [IDIM];
    logic signed [WIDTH-1:0] hidden [HIDDEN_DIM];
    logic signed [WIDTH-1:0] stage  [IDIM];

    state_t          state;
    logic [IW-1:0]   i_idx;
    logic [IW-1:0]   o_idx;
    logic [HW-1:0]   h_idx;
    logic [WW-1:0]   w_idx;

    logic                    start_ok;
    logic                    mac_run;
    logic                    mac_last;
    logic                    mac_relu;
    logic signed [WIDTH-1:0] mac_a;
    logic signed [WIDTH-1:0] mac_b;
    logic signed [WIDTH-1:0] mac_bias;
    logic signed [WIDTH-1:0] mac_res;
    logic                    mac_ovf;

    assign start_ok = start && !clear && (state == ST_IDLE || state == ST_DONE);
    assign mac_run  = !clear && (state == ST_L1 || state == ST_L2);

    // Both weight matrices are walked in storage order, so one linear pointer serves both layers.
    always_comb begin
        mac_a    = x_r[i_idx];
        mac_b    = w1_r[w_idx];
        mac_bias = b1_r[h_idx];
        mac_relu = 1'b1;
        mac_last = (i_idx == I_LAST);
        if (state == ST_L2) begin
            mac_a    = hidden[h_idx];
            mac_b    = w2_r[w_idx];
            mac_bias = b2_r[o_idx];
            mac_relu = 1'b0;
            mac_last = (h_idx == H_LAST);
        end
    end

    ffn_mac #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (mac_run),
        .last   (mac_last),
        .clr    (start_ok || clear),
        .relu   (mac_relu),
        .a      (mac_a),
        .b      (mac_b),
        .bias   (mac_bias),
        .result (mac_res),
        .ovf    (mac_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < IDIM; k++) begin
                x_r[k]  <= '0;
                b2_r[k] <= '0;
            end
            for (int k = 0; k < HIDDEN_DIM; k++) b1_r[k] <= '0;
            for (int k = 0; k < NW; k++) begin
                w1_r[k] <= '0;
                w2_r[k] <= '0;
            end
        end else if (start_ok) begin
            for (int k = 0; k < IDIM; k++) begin
                x_r[k]  <= input_data[k*WIDTH +: WIDTH];
                b2_r[k] <= bias2[k*WIDTH +: WIDTH];
            end
            for (int k = 0; k < HIDDEN_DIM; k++) b1_r[k] <= bias1[k*WIDTH +: WIDTH];
            for (int k = 0; k < NW; k++) begin
                w1_r[k] <= weights1[k*WIDTH +: WIDTH];
                w2_r[k] <= weights2[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < HIDDEN_DIM; k++) hidden[k] <= '0;
            for (int k = 0; k < IDIM; k++) stage[k] <= '0;
        end else if (mac_run && mac_last) begin
            if (state == ST_L1) hidden[h_idx] <= mac_res;
            else                stage[o_idx]  <= mac_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            i_idx       <= '0;
            h_idx       <= '0;
            o_idx       <= '0;
            w_idx       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sat_flag    <= 1'b0;
            output_data <= '0;
        end else if (clear) begin
            state <= ST_IDLE;
            i_idx <= '0;
            h_idx <= '0;
            o_idx <= '0;
            w_idx <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_L1;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                    end
                end
                ST_L1: begin
                    w_idx <= w_idx + 1'b1;
                    if (mac_last && mac_ovf) sat_flag <= 1'b1;
                    if (i_idx == I_LAST) begin
                        i_idx <= '0;
                        if (h_idx == H_LAST) begin
                            h_idx <= '0;
                            w_idx <= '0;
                            state <= ST_L2;
                        end else begin
                            h_idx <= h_idx + 1'b1;
                        end
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end
                ST_L2: begin
                    w_idx <= w_idx + 1'b1;
                    if (mac_last && mac_ovf) sat_flag <= 1'b1;
                    if (h_idx == H_LAST) begin
                        h_idx <= '0;
                        if (o_idx == I_LAST) begin
                            o_idx <= '0;
                            w_idx <= '0;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end else begin
                            o_idx <= o_idx + 1'b1;
                        end
                    end else begin
                        h_idx <= h_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    done <= 1'b1;
                    for (int k = 0; k < IDIM; k++) output_data[k*WIDTH +: WIDTH] <= stage[k];
                    if (start) begin
                        state    <= ST_L1;
                        busy     <= 1'b1;
                        sat_flag <= 1'b0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ffn_seq_engine.md
Name: ffn_seq_engine

Overview:
Parametrised, sequential two-layer feedforward engine: out = W2·ReLU(W1·x + b1) + b2, in signed fixed point. It uses one time-multiplexed MAC with a start/busy/done handshake, saturating arithmetic and a sticky overflow flag. It drops into the encoder/decoder layers wherever the FFN stage sits, fed by the attention output and the layer's weight/bias buses.

Parameters:
IDIM, 4, input/output feature count
HIDDEN_DIM, 8, hidden-layer feature count
WIDTH, 8, element width, signed two's complement
FRAC, 4, fractional bits (Q(WIDTH-FRAC).FRAC)
ACC_W, 2*WIDTH+$clog2(max(IDIM,HIDDEN_DIM))+1, accumulator width (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; accepted in IDLE or DONE only
clear  in  1  synchronous abort to IDLE
input_data  in  IDIM*WIDTH  x[i] at [i*WIDTH +: WIDTH]
weights1  in  HIDDEN_DIM*IDIM*WIDTH  W1[h][i] at index h*IDIM+i
bias1  in  HIDDEN_DIM*WIDTH  b1[h]
weights2  in  IDIM*HIDDEN_DIM*WIDTH  W2[o][h] at index o*HIDDEN_DIM+h
bias2  in  IDIM*WIDTH  b2[o]
output_data  out  IDIM*WIDTH  y[o]; held until the next completed run
busy  out  1  high in L1/L2
done  out  1  one-cycle pulse
sat_flag  out  1  a saturation occurred during the last run

Behaviour:
- Reset and interface: rst_n asynchronous, active-low; clock clk. Reset clears output_data, busy, done, sat_flag, internal registers and counters; FSM goes to IDLE.
- FSM states IDLE, L1, L2, DONE.
  - IDLE/DONE + start: capture all operand buses into internal registers, clear sat_flag and the accumulator, go to L1.
  - L1: one MAC per cycle over i (inner) and h (outer). On the last i, write hidden[h] = sat(ReLU((acc>>>FRAC)+b1[h])), clear acc, advance h. After h=HIDDEN_DIM-1, go to L2.
  - L2: same pattern over h (inner) and o (outer), no ReLU. Write y[o] into the output staging register. After o=IDIM-1, go to DONE.
  - DONE: lasts 1 cycle. output_data updates from staging, done=1. Without start, go to IDLE.
- Latency: start sampled at edge 0; done high after edge 2*IDIM*HIDDEN_DIM+1 (edge 65 at defaults). busy is high for exactly 2*IDIM*HIDDEN_DIM cycles.
- Write-back happens in the same cycle as the last MAC of each element, using acc+product, so there are no bubbles.
- Arithmetic:
  - Products are full 2*WIDTH signed; the accumulator is ACC_W, so it cannot overflow.
  - Rescale by arithmetic shift right by FRAC (floor), then add the bias sign-extended.
  - ReLU (L1 only) is applied before saturation.
  - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Any clamp sets sat_flag, which is sticky until the next accepted start.
- Operands are captured at start; bus changes during a run have no effect.
- start during L1/L2 is ignored, with no restart and no error.
- start during DONE is accepted: done still pulses that cycle, and the next state is L1.
- clear: highest priority after reset. From any state, go to IDLE next edge. busy goes low, no done pulse, output_data and sat_flag are unchanged. clear and start in the same cycle: clear wins.
- rst_n asserted mid-run aborts immediately; no done follows.

Decomposition:
- Package ffn_pkg holds:
  - the state enum
  - an ACC_W helper function
  - the signed saturate function (value, width → clamped value + overflow bit)
- Sub-module ffn_mac holds the signed multiply, accumulator register, clear/last controls, shift, bias add, optional ReLU and saturate, with result and overflow outputs.
- Top level holds the FSM, the index counters (i/h/o), operand registers, the hidden buffer and the output staging register.

Test Plan:
- Defaults. W1[h][i]=0x10 if h==i else 0; W2[o][h]=0x10 if o==h else 0; biases 0; x={0x10,0x20,0xF0,0x08} → output {0x10,0x20,0x00,0x08}, done pulse only after edge 65, sat_flag=0.
- All weights 0x7F, x all 0x7F, biases 0 → hidden clamps to 0x7F, output all 0x7F, sat_flag=1. Then run the identity test again → sat_flag=0.
- Weights 0, b1 arbitrary, b2 all 0xE0 → output all 0xE0 (-2.0), sat_flag=0.
- start re-pulsed at edges 5 and 30, operand buses changed mid-run → exactly one done at edge 65, results from the original operands.
- Run 1 completes; start run 2; clear at edge 10 → busy low after edge 11, no done, output_data still holds the run-1 result. Then start → normal completion.
- Back-to-back: start held during the DONE cycle → second done at 65 cycles after the first. Then rst_n pulsed low mid-run at cycle 20 → all outputs 0 immediately, no done.
